// File: rtl/up_down_count_pkg.sv
// Shared types for the up/down counter monitor.
//   state_e : monitor FSM states
//   step_e  : classification of one observed step (prev -> current)
//   ERR_*   : values reported on err_code
package up_down_count_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    LOCK_UP = 3'd2,
    LOCK_DN = 3'd3,
    ERR     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    STEP_UP  = 2'd0,
    STEP_DN  = 2'd1,
    STEP_ILL = 2'd2
  } step_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OOR  = 2'b01;
  localparam logic [1:0] ERR_STEP = 2'b10;

endpackage

// File: rtl/count_step_classifier.sv
// Combinational classifier for one step of a 0..MAX up/down counter.
// Ports:
//   prev_i    : previous (in-range) counter value
//   cur_i     : current sample
//   step_o    : STEP_UP / STEP_DN / STEP_ILL
//   oor_o     : current sample is above MAX
//   wrap_up_o : legal up step MAX -> 0
//   wrap_dn_o : legal down step 0 -> MAX
// The wrap points are compared explicitly because MAX+1 is generally not a
// power of two, so plain WIDTH-bit modular arithmetic would be wrong.
module count_step_classifier
  import up_down_count_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 8
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] cur_i,
  output step_e            step_o,
  output logic             oor_o,
  output logic             wrap_up_o,
  output logic             wrap_dn_o
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] up_next_s;
  logic [WIDTH-1:0] dn_next_s;

  // Expected successor values in each direction, then classification.
  always_comb begin
    up_next_s = (prev_i == MAX_V)  ? ZERO_V : (prev_i + ONE_V);
    dn_next_s = (prev_i == ZERO_V) ? MAX_V  : (prev_i - ONE_V);
    oor_o     = (cur_i > MAX_V);
    step_o    = STEP_ILL;
    wrap_up_o = 1'b0;
    wrap_dn_o = 1'b0;
    if (cur_i == up_next_s) begin
      step_o    = STEP_UP;
      wrap_up_o = (prev_i == MAX_V);
    end else if (cur_i == dn_next_s) begin
      step_o    = STEP_DN;
      wrap_dn_o = (prev_i == ZERO_V);
    end else begin
      step_o    = STEP_ILL;
    end
  end

endmodule

// File: rtl/up_down_count_monitor.sv
// Passive monitor for a 0..MAX up/down counter bus.
// Ports:
//   clk        : rising-edge clock shared with the observed counter
//   rst        : asynchronous active-low reset
//   sample_en  : count_in is valid this cycle
//   count_in   : observed counter value
//   clr_err    : clear error and resynchronise (wins over a same-cycle sample)
//   dir        : last legal step direction (1 = up)
//   dir_valid  : monitor is locked to a direction
//   dir_change : pulse on a legal reversal between the two lock states
//   wrap_up    : pulse on a legal MAX -> 0 step
//   wrap_dn    : pulse on a legal 0 -> MAX step
//   wrap_count : saturating count of all wraps
//   err        : sticky error flag
//   err_code   : cause of the first error (ERR_OOR / ERR_STEP)
// All outputs are registered and reflect a sample one clock after it.
module up_down_count_monitor
  import up_down_count_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 8,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clr_err,
  output logic             dir,
  output logic             dir_valid,
  output logic             dir_change,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic [WRAPW-1:0] wrap_count,
  output logic             err,
  output logic [1:0]       err_code
);

  if ((MAX < 2) || (MAX > (2 ** WIDTH) - 1)) begin : g_bad_max
    $error("up_down_count_monitor: MAX out of range for WIDTH");
  end

  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic             dir_q;
  logic             dir_valid_q;
  logic             dir_change_q;
  logic             wrap_up_q;
  logic             wrap_dn_q;
  logic [WRAPW-1:0] wrap_count_q;
  logic [WRAPW-1:0] wrap_count_d;
  logic             err_q;
  logic [1:0]       err_code_q;

  step_e            step_s;
  logic             oor_s;
  logic             cls_wrap_up_s;
  logic             cls_wrap_dn_s;

  count_step_classifier #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_classifier (
    .prev_i    (prev_q),
    .cur_i     (count_in),
    .step_o    (step_s),
    .oor_o     (oor_s),
    .wrap_up_o (cls_wrap_up_s),
    .wrap_dn_o (cls_wrap_dn_s)
  );

  // Saturating successor of the wrap counter.
  always_comb begin
    if (wrap_count_q == {WRAPW{1'b1}}) begin
      wrap_count_d = wrap_count_q;
    end else begin
      wrap_count_d = wrap_count_q + WRAPW'(1);
    end
  end

  // Monitor FSM with all output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      dir_q        <= 1'b0;
      dir_valid_q  <= 1'b0;
      dir_change_q <= 1'b0;
      wrap_up_q    <= 1'b0;
      wrap_dn_q    <= 1'b0;
      wrap_count_q <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      dir_change_q <= 1'b0;
      wrap_up_q    <= 1'b0;
      wrap_dn_q    <= 1'b0;
      if (clr_err) begin
        state_q     <= IDLE;
        dir_valid_q <= 1'b0;
        err_q       <= 1'b0;
        err_code_q  <= ERR_NONE;
      end else if (sample_en) begin
        case (state_q)
          IDLE: begin
            if (oor_s) begin
              state_q     <= ERR;
              dir_valid_q <= 1'b0;
              err_q       <= 1'b1;
              err_code_q  <= ERR_OOR;
            end else begin
              state_q     <= SYNC;
              prev_q      <= count_in;
              dir_valid_q <= 1'b0;
            end
          end
          SYNC, LOCK_UP, LOCK_DN: begin
            if (oor_s) begin
              state_q     <= ERR;
              dir_valid_q <= 1'b0;
              err_q       <= 1'b1;
              err_code_q  <= ERR_OOR;
            end else if (step_s == STEP_ILL) begin
              state_q     <= ERR;
              dir_valid_q <= 1'b0;
              err_q       <= 1'b1;
              err_code_q  <= ERR_STEP;
            end else begin
              prev_q       <= count_in;
              dir_q        <= (step_s == STEP_UP);
              dir_valid_q  <= 1'b1;
              state_q      <= (step_s == STEP_UP) ? LOCK_UP : LOCK_DN;
              // A reversal only counts between the two locked states.
              dir_change_q <= ((state_q == LOCK_UP) && (step_s == STEP_DN)) ||
                              ((state_q == LOCK_DN) && (step_s == STEP_UP));
              wrap_up_q    <= cls_wrap_up_s;
              wrap_dn_q    <= cls_wrap_dn_s;
              if (cls_wrap_up_s || cls_wrap_dn_s) begin
                wrap_count_q <= wrap_count_d;
              end else begin
                wrap_count_q <= wrap_count_q;
              end
            end
          end
          ERR: begin
            // Samples are ignored until clr_err.
            state_q <= ERR;
          end
          default: begin
            state_q     <= IDLE;
            dir_valid_q <= 1'b0;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign dir        = dir_q;
  assign dir_valid  = dir_valid_q;
  assign dir_change = dir_change_q;
  assign wrap_up    = wrap_up_q;
  assign wrap_dn    = wrap_dn_q;
  assign wrap_count = wrap_count_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_up_down_count_monitor.sv
module tb_up_down_count_monitor;

  localparam int WIDTH = 4;
  localparam int MAX   = 8;
  localparam int WRAPW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_en;
  logic [WIDTH-1:0] count_in;
  logic             clr_err;
  logic             dir;
  logic             dir_valid;
  logic             dir_change;
  logic             wrap_up;
  logic             wrap_dn;
  logic [WRAPW-1:0] wrap_count;
  logic             err;
  logic [1:0]       err_code;

  int n_checks = 0;
  int n_fail   = 0;

  up_down_count_monitor #(.WIDTH(WIDTH), .MAX(MAX), .WRAPW(WRAPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .count_in   (count_in),
    .clr_err    (clr_err),
    .dir        (dir),
    .dir_valid  (dir_valid),
    .dir_change (dir_change),
    .wrap_up    (wrap_up),
    .wrap_dn    (wrap_dn),
    .wrap_count (wrap_count),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // Reference model: "have a previous value", "locked", last direction,
  // sticky error, computed with modular arithmetic on the range 0..MAX.
  bit       m_have_prev, m_locked, m_dir, m_chg, m_wu, m_wd, m_err;
  int       m_p;
  logic [7:0] m_wraps;
  logic [1:0] m_code;

  task automatic model_reset();
    m_have_prev = 0; m_locked = 0; m_dir = 0; m_chg = 0; m_wu = 0; m_wd = 0;
    m_err = 0; m_p = 0; m_wraps = 8'd0; m_code = 2'b00;
  endtask

  task automatic model_fault(input logic [1:0] code);
    m_err = 1; m_code = code; m_have_prev = 0; m_locked = 0;
  endtask

  task automatic model_apply(input bit clr, input bit en, input int c);
    bit is_up, is_dn;
    m_chg = 0; m_wu = 0; m_wd = 0;
    if (clr) begin
      m_err = 0; m_code = 2'b00; m_have_prev = 0; m_locked = 0;
    end else if (en && !m_err) begin
      if (c > MAX) model_fault(2'b01);
      else if (!m_have_prev) begin
        m_p = c; m_have_prev = 1;
      end else begin
        is_up = (c == (m_p + 1) % (MAX + 1));
        is_dn = (c == (m_p + MAX) % (MAX + 1));
        if (!is_up && !is_dn) model_fault(2'b10);
        else begin
          m_chg    = m_locked && (m_dir != is_up);
          m_locked = 1;
          m_dir    = is_up;
          m_wu     = is_up && (c == 0);
          m_wd     = is_dn && (c == MAX);
          if ((m_wu || m_wd) && m_wraps != 8'd255) m_wraps = m_wraps + 8'd1;
          m_p = c;
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_v();
    return {m_dir, m_locked, m_chg, m_wu, m_wd, m_wraps, m_err, m_code};
  endfunction

  function automatic logic [15:0] obs_v();
    return {dir, dir_valid, dir_change, wrap_up, wrap_dn, wrap_count, err, err_code};
  endfunction

  // Drive one cycle of stimulus and advance the model; sampling is #1 after the edge.
  task automatic drive(input bit clr, input bit en, input int c);
    @(negedge clk);
    clr_err   = clr;
    sample_en = en;
    count_in  = c[WIDTH-1:0];
    @(posedge clk);
    #1;
    model_apply(clr, en, c);
    clr_err   = 1'b0;
    sample_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; sample_en = 1'b0; clr_err = 1'b0; count_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_v() !== 16'h0000) begin
      n_fail++; $display("FAIL reset outputs obs=%h exp=%h", obs_v(), 16'h0000);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_up_sequence();
    int seq [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0, 1};
    drive(1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      drive(0, 1, seq[i]);
      n_checks++;
      if (obs_v() !== exp_v()) begin
        n_fail++; $display("FAIL up_seq[%0d] obs=%h exp=%h", i, obs_v(), exp_v());
      end
      if (i == 1) begin
        n_checks++;
        if ({dir_valid, dir} !== 2'b11) begin
          n_fail++; $display("FAIL up_lock dv,dir=%b exp=11", {dir_valid, dir});
        end
      end
      n_checks++;
      if (wrap_up !== (i == 9)) begin
        n_fail++; $display("FAIL up_wrap_pulse[%0d] wrap_up=%b exp=%b", i, wrap_up, (i == 9));
      end
    end
    n_checks++;
    if ({wrap_count, err} !== {8'd1, 1'b0}) begin
      n_fail++; $display("FAIL up_wrap_count count=%0d err=%b exp 1,0", wrap_count, err);
    end
  endtask

  task automatic test_down_sequence();
    int seq [6] = '{3, 2, 1, 0, 8, 7};
    int n_wd = 0;
    int n_chg = 0;
    drive(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, seq[i]);
      n_wd  += int'(wrap_dn);
      n_chg += int'(dir_change);
      n_checks++;
      if (obs_v() !== exp_v()) begin
        n_fail++; $display("FAIL dn_seq[%0d] obs=%h exp=%h", i, obs_v(), exp_v());
      end
    end
    n_checks++;
    if ({dir, n_wd[3:0], n_chg[3:0]} !== {1'b0, 4'd1, 4'd0}) begin
      n_fail++; $display("FAIL dn_summary dir=%b wrap_dn=%0d chg=%0d exp 0,1,0", dir, n_wd, n_chg);
    end
  endtask

  task automatic test_reversal();
    int seq [5] = '{4, 5, 6, 5, 4};
    drive(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, seq[i]);
      n_checks++;
      if (obs_v() !== exp_v()) begin
        n_fail++; $display("FAIL rev_seq[%0d] obs=%h exp=%h", i, obs_v(), exp_v());
      end
      n_checks++;
      if (dir_change !== (i == 3)) begin
        n_fail++; $display("FAIL rev_pulse[%0d] dir_change=%b exp=%b", i, dir_change, (i == 3));
      end
    end
    n_checks++;
    if ({dir, dir_valid} !== 2'b01) begin
      n_fail++; $display("FAIL rev_final dir,dv=%b exp=01", {dir, dir_valid});
    end
  endtask

  task automatic test_oor();
    logic [15:0] snap;
    drive(1, 0, 0);
    drive(0, 1, 5);
    drive(0, 1, 6);
    drive(0, 1, 9);
    n_checks++;
    if ({err, err_code, dir_valid} !== {1'b1, 2'b01, 1'b0}) begin
      n_fail++; $display("FAIL oor_entry err,code,dv=%b exp=1010", {err, err_code, dir_valid});
    end
    snap = obs_v();
    drive(0, 1, 7);
    n_checks++;
    if (obs_v() !== snap || obs_v() !== exp_v()) begin
      n_fail++; $display("FAIL oor_ignored obs=%h exp=%h", obs_v(), exp_v());
    end
    drive(1, 0, 0);
    n_checks++;
    if ({err, err_code, dir_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL oor_clear err,code,dv=%b exp=0000", {err, err_code, dir_valid});
    end
    drive(0, 1, 7);
    drive(0, 1, 8);
    n_checks++;
    if ({dir_valid, dir} !== 2'b11 || obs_v() !== exp_v()) begin
      n_fail++; $display("FAIL oor_relock obs=%h exp=%h", obs_v(), exp_v());
    end
  endtask

  task automatic test_illegal_step();
    drive(1, 0, 0);
    drive(0, 1, 2);
    drive(0, 1, 5);
    n_checks++;
    if ({err, err_code} !== 3'b110) begin
      n_fail++; $display("FAIL ill_entry err,code=%b exp=110", {err, err_code});
    end
    drive(0, 1, 15);
    n_checks++;
    if ({err, err_code} !== 3'b110 || obs_v() !== exp_v()) begin
      n_fail++; $display("FAIL ill_first_kept obs=%h exp=%h", obs_v(), exp_v());
    end
  endtask

  task automatic test_clr_with_sample();
    drive(1, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 1);
    drive(1, 1, 2);
    n_checks++;
    if ({dir_valid, err} !== 2'b00 || obs_v() !== exp_v()) begin
      n_fail++; $display("FAIL clr_wins obs=%h exp=%h", obs_v(), exp_v());
    end
    drive(0, 1, 3);
    n_checks++;
    if (dir_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_resync_first dv=%b exp=0", dir_valid);
    end
    drive(0, 1, 4);
    n_checks++;
    if (dir_valid !== 1'b1 || obs_v() !== exp_v()) begin
      n_fail++; $display("FAIL clr_resync_second obs=%h exp=%h", obs_v(), exp_v());
    end
  endtask

  task automatic test_saturate();
    int bad = 0;
    drive(1, 0, 0);
    for (int i = 0; i <= 300 * (MAX + 1); i++) begin
      drive(0, 1, i % (MAX + 1));
      if (obs_v() !== exp_v()) begin
        bad++;
        if (bad < 5) $display("FAIL sat_seq[%0d] obs=%h exp=%h", i, obs_v(), exp_v());
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
    n_checks++;
    if (wrap_count !== 8'd255) begin
      n_fail++; $display("FAIL sat_value wrap_count=%0d exp=255", wrap_count);
    end
  endtask

  task automatic test_random();
    int r, c;
    bit clr, en;
    int bad = 0;
    drive(1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      clr = (r < 4);
      en  = !(r >= 4 && r < 12);
      if (r >= 12 && r < 16)       c = $urandom_range(MAX + 1, 15);
      else if (r >= 16 && r < 24)  c = $urandom_range(0, MAX);
      else if ($urandom_range(0, 3) != 0) c = (m_p + 1) % (MAX + 1);
      else                          c = (m_p + MAX) % (MAX + 1);
      drive(clr, en, c);
      if (obs_v() !== exp_v()) begin
        bad++;
        if (bad < 5) $display("FAIL rand[%0d] obs=%h exp=%h", i, obs_v(), exp_v());
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0);
    drive(0, 1, 0);
    drive(0, 1, 1);
    drive(0, 1, 2);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs_v() !== 16'h0000) begin
      n_fail++; $display("FAIL async_reset obs=%h exp=%h", obs_v(), 16'h0000);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1, 3);
    n_checks++;
    if (dir_valid !== 1'b0 || obs_v() !== exp_v()) begin
      n_fail++; $display("FAIL post_reset_first obs=%h exp=%h", obs_v(), exp_v());
    end
    drive(0, 1, 4);
    n_checks++;
    if (dir_valid !== 1'b1 || obs_v() !== exp_v()) begin
      n_fail++; $display("FAIL post_reset_second obs=%h exp=%h", obs_v(), exp_v());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_up_sequence();
    test_down_sequence();
    test_reversal();
    test_oor();
    test_illegal_step();
    test_clr_with_sample();
    test_saturate();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
